// File: rtl/jk_trig.sv
// ---------------------------------------------------------------------------
// jk_trig : bank of WIDTH independent positive-edge JK flip-flops with
// complementary outputs.
//
// Ports
//   i_clk  : clock; every state change happens on its rising edge
//   i_rst  : asynchronous, active-high reset; clears all bits to 0
//   i_j    : [WIDTH-1:0] J (set) input, bit n drives flip-flop n
//   i_k    : [WIDTH-1:0] K (reset) input, bit n drives flip-flop n
//   o_q    : [WIDTH-1:0] registered state Q
//   o_qb   : [WIDTH-1:0] complement of Q, combinational from the register
//
// Handshake: none. This block has no valid/ready interface; i_j/i_k are
// sampled on every rising edge of i_clk while i_rst is low, and o_q is
// always valid.
// ---------------------------------------------------------------------------
module jk_trig #(
  parameter int WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_j,
  input  logic [WIDTH-1:0] i_k,
  output logic [WIDTH-1:0] o_q,
  output logic [WIDTH-1:0] o_qb
);

  logic [WIDTH-1:0] q;

  // JK characteristic equation, evaluated bitwise:
  //   q+ = (J & ~q) | (~K & q)
  //   00 -> hold, 01 -> 0, 10 -> 1, 11 -> toggle
  // Reset sits on the async sensitivity so it wins over a coincident edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      q <= '0;
    end else begin
      q <= (i_j & ~q) | (~i_k & q);
    end
  end

  assign o_q  = q;
  // Derived from the register rather than stored separately, so Q and QB
  // can never disagree, including during reset.
  assign o_qb = ~q;

endmodule

// File: tb/tb_jk_trig.sv
// ---------------------------------------------------------------------------
// tb_jk_trig : self-checking bench for jk_trig. Two instances share one
// 20 ns clock: a WIDTH=1 bank and a WIDTH=4 bank. The driver applies inputs
// on falling edges and pushes the hand-computed Q expected after the next
// rising edge; the monitor pops and compares 1 ns after each rising edge.
// Asynchronous reset behaviour between edges is checked directly.
// ---------------------------------------------------------------------------
module tb_jk_trig;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       j1, k1;
  logic [3:0] j4, k4;
  logic       q1, qb1;
  logic [3:0] q4, qb4;

  always #10 clk = ~clk;

  jk_trig #(.WIDTH(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_j(j1), .i_k(k1), .o_q(q1), .o_qb(qb1)
  );

  jk_trig #(.WIDTH(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_j(j4), .i_k(k4), .o_q(q4), .o_qb(qb4)
  );

  // ---------------- scoreboard ----------------
  logic [0:0] exp1_q[$];
  logic [3:0] exp4_q[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one expected entry per checked rising edge.
  always @(posedge clk) begin
    #1;
    if (exp1_q.size() > 0) begin
      logic [0:0] e1;
      e1 = exp1_q.pop_front();
      check("w1_q",  {3'b000, q1},  {3'b000, e1});
      check("w1_qb", {3'b000, qb1}, {3'b000, ~e1});
    end
    if (exp4_q.size() > 0) begin
      logic [3:0] e4;
      e4 = exp4_q.pop_front();
      check("w4_q",  q4,  e4);
      check("w4_qb", qb4, ~e4);
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input logic r, input logic j1v, input logic k1v,
                       input logic [3:0] j4v, input logic [3:0] k4v,
                       input logic e1, input logic [3:0] e4, input bit glitch);
    @(negedge clk);
    rst = r;
    j1 = j1v; k1 = k1v; j4 = j4v; k4 = k4v;
    exp1_q.push_back(e1);
    exp4_q.push_back(e4);
    if (glitch) begin
      // Inputs wiggle well before the next rising edge and settle back.
      #3; j1 = 1'b1; k1 = 1'b1; j4 = 4'hf; k4 = 4'hf;
      #3; j1 = j1v;  k1 = k1v;  j4 = j4v;  k4 = k4v;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    j1 = 1'b1; k1 = 1'b1; j4 = 4'hf; k4 = 4'hf;
    #1;
    // Reset takes effect before any clock edge.
    check("rst_async_q1",  {3'b000, q1},  4'b0000);
    check("rst_async_qb1", {3'b000, qb1}, 4'b0001);
    check("rst_async_q4",  q4,  4'b0000);
    check("rst_async_qb4", qb4, 4'b1111);

    // Reset held across edges with toggle inputs: state must stay 0.
    drive(1, 1, 1, 4'hf, 4'hf, 0, 4'h0, 0);
    drive(1, 1, 1, 4'hf, 4'hf, 0, 4'h0, 0);

    // Release; w1 walks JK=00,01,10,11; w4 loads 0011 then applies the mix.
    drive(0, 0, 0, 4'b0011, 4'b0000, 0, 4'b0011, 0); // hold / set low bits
    drive(0, 0, 1, 4'b1010, 4'b0110, 0, 4'b1001, 0); // reset / set,rst,tgl,hold
    drive(0, 1, 0, 4'b0000, 4'b0000, 1, 4'b1001, 0); // set
    drive(0, 1, 1, 4'b0000, 4'b0000, 0, 4'b1001, 0); // toggle 1 -> 0

    // Repeated toggle from q=0.
    drive(0, 1, 1, 4'b0000, 4'b0000, 1, 4'b1001, 0);
    drive(0, 1, 1, 4'b0000, 4'b0000, 0, 4'b1001, 0);
    drive(0, 1, 1, 4'b0000, 4'b0000, 1, 4'b1001, 0);
    drive(0, 1, 1, 4'b0000, 4'b0000, 0, 4'b1001, 0);

    // Set, then hold for 3 edges while J/K glitch between edges.
    drive(0, 1, 0, 4'b0000, 4'b0000, 1, 4'b1001, 0);
    drive(0, 0, 0, 4'b0000, 4'b0000, 1, 4'b1001, 1);
    drive(0, 0, 0, 4'b0000, 4'b0000, 1, 4'b1001, 1);
    drive(0, 0, 0, 4'b0000, 4'b0000, 1, 4'b1001, 1);

    // Asynchronous reset mid-operation with J=1,K=0 pending.
    drive(0, 1, 0, 4'b0000, 4'b0000, 1, 4'b1001, 0);
    @(posedge clk);
    #5;
    rst = 1'b1;
    #1;
    check("rst_mid_q1",  {3'b000, q1},  4'b0000);
    check("rst_mid_qb1", {3'b000, qb1}, 4'b0001);
    check("rst_mid_q4",  q4,  4'b0000);
    check("rst_mid_qb4", qb4, 4'b1111);
    drive(1, 1, 0, 4'b1111, 4'b0000, 0, 4'b0000, 0);
    drive(1, 1, 0, 4'b1111, 4'b0000, 0, 4'b0000, 0);
    // First edge after release sets.
    drive(0, 1, 0, 4'b1111, 4'b0000, 1, 4'b1111, 0);

    // Let the monitor drain the last entry, then confirm nothing was left.
    @(posedge clk);
    #3;
    check("drain_w1", exp1_q.size(), 4'd0);
    check("drain_w4", exp4_q.size(), 4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog: the run is a few dozen cycles; anything longer is a hang.
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
